// File: rtl/ntt_addr_seq.sv
// -----------------------------------------------------------------------------
// ntt_addr_seq
//
// Walks the 128-entry NTT butterfly address ROM once per start pulse and
// presents each 28-bit word as four 7-bit lane addresses, tagged with the ROM
// index and butterfly stage, on a valid/ready stream. The 1-cycle ROM read
// latency is absorbed by a 2-entry output FIFO. Reads are throttled by credits
// so the FIFO can never overflow, while one entry per cycle still flows
// whenever the consumer keeps out_ready high.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse, begins a sequence when idle
//   rom_addr   ROM read address (held when no read is issued)
//   rom_data   ROM read data, valid one cycle after rom_addr
//   out_valid  entry available at the FIFO head
//   out_ready  consumer accepts the head entry
//   out_lane3..out_lane0  rom word bits [27:21], [20:14], [13:7], [6:0]
//   out_idx    ROM index of the presented entry
//   out_stage  out_idx[6:5]; 3 marks the final pair-mode stage
//   out_last   presented entry is index 127
//   busy       sequence in progress
//   done       one-cycle pulse after the final entry is accepted
// -----------------------------------------------------------------------------
module ntt_addr_seq #(
   parameter int DATA_WIDTH = 28,
   parameter int LANE_W     = 7,
   parameter int IDX_W      = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [IDX_W-1:0]      rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANE_W-1:0]     out_lane3,
   output logic [LANE_W-1:0]     out_lane2,
   output logic [LANE_W-1:0]     out_lane1,
   output logic [LANE_W-1:0]     out_lane0,
   output logic [IDX_W-1:0]      out_idx,
   output logic [1:0]            out_stage,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0]      idx;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   state_t           state_q;
   state_t           state_d;

   // One bit wider than the index so the terminal count 2^IDX_W is
   // representable and the walk stops instead of wrapping.
   logic [IDX_W:0]   issue_cnt_q;
   logic [IDX_W-1:0] rom_addr_q;

   // A read issued last cycle whose data is on rom_data this cycle.
   logic             inflight_q;
   logic [IDX_W-1:0] inflight_idx_q;

   entry_t           fifo_mem [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       fifo_cnt_q;
   logic             done_q;

   entry_t           head;
   logic             pop;
   logic             push;
   logic             issue;
   logic             last_hs;
   logic [1:0]       credits_used;

   // ---------------------------------------------------------------------------
   // Output stream: FIFO head, sliced into lanes
   // ---------------------------------------------------------------------------
   assign head      = fifo_mem[rd_ptr_q];
   assign out_valid = (fifo_cnt_q != 2'd0);
   assign out_lane3 = head.data[4*LANE_W-1:3*LANE_W];
   assign out_lane2 = head.data[3*LANE_W-1:2*LANE_W];
   assign out_lane1 = head.data[2*LANE_W-1:LANE_W];
   assign out_lane0 = head.data[LANE_W-1:0];
   assign out_idx   = head.idx;
   assign out_stage = head.idx[IDX_W-1:IDX_W-2];
   assign out_last  = &head.idx;
   assign busy      = (state_q == RUN);
   assign done      = done_q;

   // ---------------------------------------------------------------------------
   // Handshake, capture and issue control
   // ---------------------------------------------------------------------------
   assign pop     = out_valid & out_ready;
   assign push    = inflight_q;
   assign last_hs = pop & out_last & (state_q == RUN);

   // Slots committed to the FIFO after this cycle. A head popped this cycle
   // frees its slot immediately; without that, the 2-entry FIFO could not
   // sustain one entry per cycle across the 1-cycle ROM latency.
   assign credits_used = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

   assign issue = (state_q == RUN) && !issue_cnt_q[IDX_W] && (credits_used < 2'd2);

   // The address is presented combinationally in the issue cycle so the ROM
   // registers it at the same edge that records the read as in flight.
   assign rom_addr = issue ? issue_cnt_q[IDX_W-1:0] : rom_addr_q;

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)   state_d = RUN;
         RUN:     if (last_hs) state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   // NOTE: state uses non-blocking assignments so every register samples the
   // values from before the edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         issue_cnt_q    <= '0;
         rom_addr_q     <= '0;
         inflight_q     <= 1'b0;
         inflight_idx_q <= '0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
         fifo_cnt_q     <= 2'd0;
         done_q         <= 1'b0;
         // NOTE: the two FIFO slots are reset because the head drives the
         // outputs directly, and those must read 0 after reset. Larger
         // memories would normally be left unreset.
         for (int i = 0; i < 2; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         done_q <= last_hs;

         if ((state_q == IDLE) && start) begin
            issue_cnt_q <= '0;
         end else if (issue) begin
            issue_cnt_q <= issue_cnt_q + {{IDX_W{1'b0}}, 1'b1};
         end

         if (issue) begin
            rom_addr_q     <= issue_cnt_q[IDX_W-1:0];
            inflight_idx_q <= issue_cnt_q[IDX_W-1:0];
         end
         inflight_q <= issue;

         if (push) begin
            fifo_mem[wr_ptr_q] <= '{idx: inflight_idx_q, data: rom_data};
            wr_ptr_q           <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end

         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_addr_seq.sv
// -----------------------------------------------------------------------------
// tb_ntt_addr_seq
//
// Directed bench for ntt_addr_seq. A registered-read ROM model supplies a
// golden table of 128 words; known butterfly words sit at the indices with
// hand-computed lane values, the rest are filled by a simple pattern.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Cycle c of a sequence is the cycle c edges after the one
// in which start was driven.
// -----------------------------------------------------------------------------
module tb_ntt_addr_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [6:0]  rom_addr;
   logic [27:0] rom_data;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_lane3;
   logic [6:0]  out_lane2;
   logic [6:0]  out_lane1;
   logic [6:0]  out_lane0;
   logic [6:0]  out_idx;
   logic [1:0]  out_stage;
   logic        out_last;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [27:0] rom [0:127];

   always #5 clk = ~clk;

   ntt_addr_seq #(
      .DATA_WIDTH(28),
      .LANE_W    (7),
      .IDX_W     (7)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_lane3(out_lane3),
      .out_lane2(out_lane2),
      .out_lane1(out_lane1),
      .out_lane0(out_lane0),
      .out_idx  (out_idx),
      .out_stage(out_stage),
      .out_last (out_last),
      .busy     (busy),
      .done     (done)
   );

   // ROM with one-cycle registered read.
   always @(posedge clk) begin
      rom_data <= rom[rom_addr];
   end

   // Word as {lane3, lane2, lane1, lane0}.
   function automatic logic [27:0] make_word(input int i);
      logic [6:0] v;
      v = 7'(i);
      case (i)
         0:       return {7'd96,  7'd32,  7'd64, 7'd64};
         32:      return {7'd72,  7'd8,   7'd16, 7'd16};
         40:      return {7'd104, 7'd40,  7'd80, 7'd80};
         64:      return {7'd66,  7'd2,   7'd4,  7'd4};
         96:      return {7'd1,   7'd9,   7'd0,  7'd0};
         127:     return {7'd119, 7'd127, 7'd0,  7'd0};
         default: return {v, v ^ 7'h55, 7'(i * 3), ~v};
      endcase
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if ({out_valid, busy, done, out_last} !== 4'b0000) begin
         errors++;
         $display("FAIL reset flags {valid,busy,done,last}: got %b expected 0000",
                  {out_valid, busy, done, out_last});
      end
      checks++;
      if (rom_addr !== 7'd0) begin
         errors++;
         $display("FAIL reset rom_addr: got %0d expected 0", rom_addr);
      end
      checks++;
      if ({out_idx, out_stage} !== 9'd0) begin
         errors++;
         $display("FAIL reset idx/stage: got %0d/%0d expected 0/0", out_idx, out_stage);
      end
      checks++;
      if ({out_lane3, out_lane2, out_lane1, out_lane0} !== 28'd0) begin
         errors++;
         $display("FAIL reset lanes: got %h expected 0",
                  {out_lane3, out_lane2, out_lane1, out_lane0});
      end
   endtask

   task automatic test_idle_ready();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         out_ready = 1'b1;
         @(negedge clk);
         checks++;
         if ({out_valid, busy, done} !== 3'b000 || rom_addr !== 7'd0) begin
            errors++;
            $display("FAIL idle_ready c%0d: valid/busy/done=%b addr=%0d expected 000/0",
                     c, {out_valid, busy, done}, rom_addr);
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_free_run();
      int          exp_i;
      logic [27:0] spot;
      logic        spot_en;
      do_reset();
      @(posedge clk);
      #1;
      start     = 1'b1;
      out_ready = 1'b1;
      exp_i     = 0;
      for (int c = 1; c <= 135; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         @(negedge clk);
         checks++;
         if (busy !== (c >= 1 && c <= 130)) begin
            errors++;
            $display("FAIL free_run busy c%0d: got %b expected %b", c, busy, (c >= 1 && c <= 130));
         end
         checks++;
         if (done !== (c == 131)) begin
            errors++;
            $display("FAIL free_run done c%0d: got %b expected %b", c, done, (c == 131));
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (out_idx !== 7'(exp_i) || c != exp_i + 3) begin
               errors++;
               $display("FAIL free_run order: got idx %0d at c%0d expected idx %0d at c%0d",
                        out_idx, c, exp_i, exp_i + 3);
            end
            checks++;
            if ({out_lane3, out_lane2, out_lane1, out_lane0} !== rom[exp_i & 127]) begin
               errors++;
               $display("FAIL free_run lanes idx %0d: got %h expected %h", exp_i,
                        {out_lane3, out_lane2, out_lane1, out_lane0}, rom[exp_i & 127]);
            end
            checks++;
            if (out_stage !== 2'(exp_i >> 5) || out_last !== (exp_i == 127)) begin
               errors++;
               $display("FAIL free_run tags idx %0d: got stage %0d last %b expected %0d %b",
                        exp_i, out_stage, out_last, 2'(exp_i >> 5), (exp_i == 127));
            end
            spot_en = 1'b1;
            case (exp_i)
               0:       spot = {7'd96,  7'd32,  7'd64, 7'd64};
               32:      spot = {7'd72,  7'd8,   7'd16, 7'd16};
               64:      spot = {7'd66,  7'd2,   7'd4,  7'd4};
               96:      spot = {7'd1,   7'd9,   7'd0,  7'd0};
               127:     spot = {7'd119, 7'd127, 7'd0,  7'd0};
               default: begin spot = '0; spot_en = 1'b0; end
            endcase
            if (spot_en) begin
               checks++;
               if ({out_lane3, out_lane2, out_lane1, out_lane0} !== spot) begin
                  errors++;
                  $display("FAIL free_run spot idx %0d: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d",
                           exp_i, out_lane3, out_lane2, out_lane1, out_lane0,
                           spot[27:21], spot[20:14], spot[13:7], spot[6:0]);
               end
            end
            exp_i++;
         end
      end
      checks++;
      if (exp_i != 128) begin
         errors++;
         $display("FAIL free_run count: got %0d entries expected 128", exp_i);
      end
   endtask

   task automatic test_backpressure();
      int exp_i;
      int done_cnt;
      do_reset();
      @(posedge clk);
      #1;
      start     = 1'b1;
      out_ready = 1'b1;
      exp_i     = 0;
      done_cnt  = 0;
      for (int c = 1; c <= 160; c++) begin
         @(posedge clk);
         #1;
         start     = 1'b0;
         out_ready = !(c >= 43 && c <= 52);
         @(negedge clk);
         if (c >= 43 && c <= 52) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 7'd40 ||
                {out_lane3, out_lane2, out_lane1, out_lane0} !== {7'd104, 7'd40, 7'd80, 7'd80}) begin
               errors++;
               $display("FAIL backpressure hold c%0d: got v%b idx %0d lanes %0d,%0d,%0d,%0d expected v1 idx 40 lanes 104,40,80,80",
                        c, out_valid, out_idx, out_lane3, out_lane2, out_lane1, out_lane0);
            end
            checks++;
            if (rom_addr > 7'd42) begin
               errors++;
               $display("FAIL backpressure rom_addr c%0d: got %0d expected <= 42", c, rom_addr);
            end
         end
         if (done === 1'b1) done_cnt++;
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (out_idx !== 7'(exp_i) ||
                {out_lane3, out_lane2, out_lane1, out_lane0} !== rom[exp_i & 127]) begin
               errors++;
               $display("FAIL backpressure entry: got idx %0d lanes %h expected idx %0d lanes %h",
                        out_idx, {out_lane3, out_lane2, out_lane1, out_lane0}, exp_i, rom[exp_i & 127]);
            end
            exp_i++;
         end
      end
      checks++;
      if (exp_i != 128 || done_cnt != 1) begin
         errors++;
         $display("FAIL backpressure totals: got %0d entries %0d done expected 128 1", exp_i, done_cnt);
      end
   endtask

   task automatic test_random_ready();
      int          exp_i;
      int          done_cnt;
      int          done_c;
      logic        prev_stall;
      logic [34:0] prev_vec;
      void'($urandom(32'h5eed_1234));
      do_reset();
      @(posedge clk);
      #1;
      start      = 1'b1;
      exp_i      = 0;
      done_cnt   = 0;
      done_c     = 0;
      prev_stall = 1'b0;
      prev_vec   = '0;
      for (int c = 1; c <= 1000; c++) begin
         @(posedge clk);
         #1;
         start     = 1'b0;
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 ||
                {out_idx, out_lane3, out_lane2, out_lane1, out_lane0} !== prev_vec) begin
               errors++;
               $display("FAIL random stability c%0d: got v%b %h expected v1 %h", c, out_valid,
                        {out_idx, out_lane3, out_lane2, out_lane1, out_lane0}, prev_vec);
            end
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_vec   = {out_idx, out_lane3, out_lane2, out_lane1, out_lane0};
         if (done === 1'b1) begin
            done_cnt++;
            done_c = c;
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (out_idx !== 7'(exp_i) || out_stage !== 2'(exp_i >> 5) ||
                {out_lane3, out_lane2, out_lane1, out_lane0} !== rom[exp_i & 127]) begin
               errors++;
               $display("FAIL random entry: got idx %0d stage %0d lanes %h expected idx %0d stage %0d lanes %h",
                        out_idx, out_stage, {out_lane3, out_lane2, out_lane1, out_lane0},
                        exp_i, 2'(exp_i >> 5), rom[exp_i & 127]);
            end
            exp_i++;
         end
         if (done_cnt > 0 && c > done_c + 5) break;
      end
      checks++;
      if (exp_i != 128 || done_cnt != 1) begin
         errors++;
         $display("FAIL random totals: got %0d entries %0d done expected 128 1", exp_i, done_cnt);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_start_while_busy();
      int exp_i;
      do_reset();
      @(posedge clk);
      #1;
      start     = 1'b1;
      out_ready = 1'b1;
      exp_i     = 0;
      for (int c = 1; c <= 140; c++) begin
         @(posedge clk);
         #1;
         start = (c == 53);
         @(negedge clk);
         checks++;
         if (out_valid !== (c >= 3 && c <= 130) || busy !== (c <= 130) || done !== (c == 131)) begin
            errors++;
            $display("FAIL start_busy c%0d: got valid/busy/done %b expected %b", c,
                     {out_valid, busy, done}, {(c >= 3 && c <= 130), (c <= 130), (c == 131)});
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (out_idx !== 7'(exp_i)) begin
               errors++;
               $display("FAIL start_busy order c%0d: got idx %0d expected %0d", c, out_idx, exp_i);
            end
            exp_i++;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_back_to_back();
      int  exp_idx;
      logic exp_v;
      logic exp_b;
      do_reset();
      @(posedge clk);
      #1;
      start     = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 266; c++) begin
         @(posedge clk);
         #1;
         start = (c == 131);
         @(negedge clk);
         exp_v   = (c >= 3 && c <= 130) || (c >= 134 && c <= 261);
         exp_b   = (c <= 130) || (c >= 132 && c <= 261);
         exp_idx = (c >= 134) ? c - 134 : c - 3;
         checks++;
         if (out_valid !== exp_v || busy !== exp_b || done !== (c == 131 || c == 262)) begin
            errors++;
            $display("FAIL back_to_back c%0d: got valid/busy/done %b expected %b", c,
                     {out_valid, busy, done}, {exp_v, exp_b, (c == 131 || c == 262)});
         end
         if (exp_v && out_valid === 1'b1) begin
            checks++;
            if (out_idx !== 7'(exp_idx)) begin
               errors++;
               $display("FAIL back_to_back order c%0d: got idx %0d expected %0d", c, out_idx, exp_idx);
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int first_c;
      do_reset();
      @(posedge clk);
      #1;
      start     = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 73; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         rst_n = (c != 73);
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 7'd70) begin
         errors++;
         $display("FAIL mid_reset setup: got v%b idx %0d expected v1 idx 70", out_valid, out_idx);
      end
      // Cycle 74: reset has been sampled.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL mid_reset flags: got valid/busy/done %b expected 000", {out_valid, busy, done});
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         checks++;
         if ({out_valid, done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset quiet c%0d: got valid/done %b expected 00", c, {out_valid, done});
         end
      end
      @(posedge clk);
      #1;
      start   = 1'b1;
      first_c = -1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         @(negedge clk);
         if (out_valid === 1'b1 && first_c < 0) begin
            first_c = c;
            checks++;
            if (out_idx !== 7'd0 ||
                {out_lane3, out_lane2, out_lane1, out_lane0} !== {7'd96, 7'd32, 7'd64, 7'd64}) begin
               errors++;
               $display("FAIL mid_reset restart entry: got idx %0d lanes %0d,%0d,%0d,%0d expected idx 0 lanes 96,32,64,64",
                        out_idx, out_lane3, out_lane2, out_lane1, out_lane0);
            end
         end
      end
      checks++;
      if (first_c != 3) begin
         errors++;
         $display("FAIL mid_reset restart latency: got first valid at c%0d expected c3", first_c);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         rom[i] = make_word(i);
      end
      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;

      test_reset();
      test_idle_ready();
      test_free_run();
      test_backpressure();
      test_random_ready();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_run();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
